// File: rtl/irq_ctrl_pkg.sv
// Shared types and cause-ID constants for the interrupt request front end.
// Fast-line support is selected with the IRQ_FAST_EN macro.
package irq_ctrl_pkg;

  // Handshake FSM toward the main controller.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } irq_fsm_e;

  // Machine cause IDs as reported to the controller.
  localparam logic [4:0] IRQ_ID_SW        = 5'd3;
  localparam logic [4:0] IRQ_ID_TMR       = 5'd7;
  localparam logic [4:0] IRQ_ID_EXT       = 5'd11;
  localparam logic [4:0] IRQ_ID_FAST_BASE = 5'd16;

  // Enabled interrupt causes, one bit per source.
  typedef struct packed {
    logic        software;
    logic        timer;
    logic        external;
    logic [14:0] fast;
  } irq_t;

endpackage

// File: rtl/irq_if.sv
// Interrupt lines, CSR view and request/acknowledge handshake bundle.
// The master side is the interrupt front end; the slave side is the
// environment (interrupt sources, CSR file and controller FSM).
interface irq_if #(
  parameter int NUM_FAST = 15
);
  logic                irq_software_i;
  logic                irq_timer_i;
  logic                irq_external_i;
  logic [NUM_FAST-1:0] irq_fast_i;
  logic                irq_nm_i;
  logic [31:0]         csr_mie_i;
  logic                csr_mstatus_mie_i;
  logic                debug_mode_i;
  logic                nmi_mode_i;
  logic                irq_ack_i;
  logic [31:0]         mip_o;
  logic                irq_pending_o;
  logic                irq_enabled_o;
  logic                irq_nm_o;
  logic [4:0]          irq_id_o;
  logic                irq_req_o;

  modport master (
    input  irq_software_i, irq_timer_i, irq_external_i, irq_fast_i, irq_nm_i,
    input  csr_mie_i, csr_mstatus_mie_i, debug_mode_i, nmi_mode_i, irq_ack_i,
    output mip_o, irq_pending_o, irq_enabled_o, irq_nm_o, irq_id_o, irq_req_o
  );

  modport slave (
    output irq_software_i, irq_timer_i, irq_external_i, irq_fast_i, irq_nm_i,
    output csr_mie_i, csr_mstatus_mie_i, debug_mode_i, nmi_mode_i, irq_ack_i,
    input  mip_o, irq_pending_o, irq_enabled_o, irq_nm_o, irq_id_o, irq_req_o
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: NMI, fast[14..0], external, software, timer.
// Fast-line arbitration exists only when IRQ_FAST_EN is defined.
module irq_prio_enc
  import irq_ctrl_pkg::*;
(
  input  irq_t       irqs,
  input  logic       nmi,
  output logic       valid,
  output logic       nm,
  output logic [4:0] id
);

  // Later assignments override earlier ones, so causes are listed lowest priority first.
  always_comb begin
    id = '0;
    if (irqs.timer)    id = IRQ_ID_TMR;
    if (irqs.software) id = IRQ_ID_SW;
    if (irqs.external) id = IRQ_ID_EXT;
`ifdef IRQ_FAST_EN
    for (int i = 0; i < 15; i++) begin
      if (irqs.fast[i]) id = IRQ_ID_FAST_BASE + 5'(i);
    end
`endif
    // NMI carries no numeric cause ID.
    if (nmi) id = '0;
    nm    = nmi;
    valid = nmi | irqs.timer | irqs.software | irqs.external | (|irqs.fast);
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt request front end: registers raw lines into mip, latches the
// edge-triggered NMI, masks and prioritises causes, and presents a stable
// request to the controller through a REQ/HOLD handshake.
// Fast lines are sampled and arbitrated only when IRQ_FAST_EN is defined.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_FAST = 15
)(
  input  logic clk,
  input  logic rst,
  irq_if.master bus
);

  // Bits of mip that can ever be set: software, timer, external, and the
  // fast lines actually present.
  localparam logic [31:0] MIP_MASK = {1'b0, 15'((32'd1 << NUM_FAST) - 32'd1), 16'h0888};

  logic [14:0] fast_lines;
  logic [31:0] mip_next;
  logic [31:0] mip_reg;
  logic [31:0] enabled;
  irq_t        enabled_set;
  logic        nm_prev_reg;
  logic        nmi_latch_reg;
  logic        nmi_latch_next;
  logic        nmi_clear;
  irq_fsm_e    state_reg;
  irq_fsm_e    state_next;
  logic        pending_reg;
  logic        enabled_reg;
  logic        nm_reg;
  logic [4:0]  id_reg;
  logic        pending;
  logic        eligible;
  logic        freeze;
  logic        enc_valid;
  logic        enc_nm;
  logic [4:0]  enc_id;

`ifdef IRQ_FAST_EN
  for (genvar gi = 0; gi < 15; gi++) begin : g_fast
    if (gi < NUM_FAST) begin : g_line
      assign fast_lines[gi] = bus.irq_fast_i[gi];
    end else begin : g_tie
      assign fast_lines[gi] = 1'b0;
    end
  end
`else
  assign fast_lines = '0;
`endif

  assign mip_next = {1'b0, fast_lines, 4'b0, bus.irq_external_i, 3'b0,
                     bus.irq_timer_i, 3'b0, bus.irq_software_i, 3'b0};

  // Stage 1: sample the interrupt lines, track the NMI line and hold the NMI latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      mip_reg       <= '0;
      nm_prev_reg   <= 1'b0;
      nmi_latch_reg <= 1'b0;
    end else begin
      mip_reg       <= mip_next;
      nm_prev_reg   <= bus.irq_nm_i;
      nmi_latch_reg <= nmi_latch_next;
    end
  end

  assign enabled                = mip_reg & bus.csr_mie_i & MIP_MASK;
  assign pending                = |enabled;
  assign enabled_set.software   = enabled[IRQ_ID_SW];
  assign enabled_set.timer      = enabled[IRQ_ID_TMR];
  assign enabled_set.external   = enabled[IRQ_ID_EXT];
  assign enabled_set.fast       = enabled[30:16];

  irq_prio_enc u_prio_enc (
    .irqs  (enabled_set),
    .nmi   (nmi_latch_reg),
    .valid (enc_valid),
    .nm    (enc_nm),
    .id    (enc_id)
  );

  // NMI bypasses mstatus.MIE; nothing is requested in debug or NMI mode.
  assign eligible = ~bus.debug_mode_i & ~bus.nmi_mode_i &
                    (enc_nm | (enc_valid & bus.csr_mstatus_mie_i));

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, output freeze on ack, and NMI latch update.
  always_comb begin
    state_next = state_reg;
    freeze     = 1'b0;
    nmi_clear  = 1'b0;
    case (state_reg)
      IDLE: if (eligible) state_next = REQ;
      REQ: begin
        if (bus.irq_ack_i) begin
          state_next = HOLD;
          freeze     = 1'b1;
          nmi_clear  = nm_reg;
        end else if (!eligible) begin
          state_next = IDLE;
        end
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A fresh edge in the clearing cycle wins over the clear.
    nmi_latch_next = (bus.irq_nm_i & ~nm_prev_reg) | (nmi_latch_reg & ~nmi_clear);
  end

  // Stage 2: registered request view; cause is held through the acknowledged cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 1'b0;
      enabled_reg <= 1'b0;
      nm_reg      <= 1'b0;
      id_reg      <= '0;
    end else begin
      pending_reg <= pending;
      enabled_reg <= bus.csr_mstatus_mie_i;
      if (!freeze) begin
        nm_reg <= enc_nm;
        id_reg <= enc_id;
      end
    end
  end

  assign bus.mip_o         = mip_reg;
  assign bus.irq_pending_o = pending_reg;
  assign bus.irq_enabled_o = enabled_reg;
  assign bus.irq_nm_o      = nm_reg;
  assign bus.irq_id_o      = id_reg;
  assign bus.irq_req_o     = (state_reg == REQ) & (nm_reg | (pending_reg & enabled_reg));

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl; expectations adapt to IRQ_FAST_EN.
module tb_irq_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] mip_v;

  irq_if #(.NUM_FAST(15)) bus ();

  irq_ctrl #(.NUM_FAST(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.irq_timer_i = 1'b1; bus.csr_mie_i = '1; bus.csr_mstatus_mie_i = 1'b1;
    tick(); tick();
    n_vec++; if (bus.mip_o !== 32'h0) begin n_err++; $display("FAIL rst_mip: got %h want 0", bus.mip_o); end
    n_vec++; if (bus.irq_pending_o !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", bus.irq_pending_o); end
    n_vec++; if (bus.irq_enabled_o !== 1'b0) begin n_err++; $display("FAIL rst_enabled: got %b want 0", bus.irq_enabled_o); end
    n_vec++; if (bus.irq_nm_o !== 1'b0) begin n_err++; $display("FAIL rst_nm: got %b want 0", bus.irq_nm_o); end
    n_vec++; if (bus.irq_id_o !== 5'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", bus.irq_id_o); end
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.irq_req_o); end
    $display("reset: outputs checked under active reset");
    bus.irq_timer_i = 1'b0; bus.csr_mie_i = '0; bus.csr_mstatus_mie_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_timer();
    bus.csr_mie_i = 32'h0000_0080; bus.csr_mstatus_mie_i = 1'b1;
    tick();
    bus.irq_timer_i = 1'b1;
    tick();
    n_vec++; if (bus.mip_o !== 32'h0000_0080) begin n_err++; $display("FAIL tmr_mip: got %h want 00000080", bus.mip_o); end
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL tmr_req_early: got %b want 0", bus.irq_req_o); end
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL tmr_req: got %b want 1", bus.irq_req_o); end
    n_vec++; if (bus.irq_id_o !== 5'd7) begin n_err++; $display("FAIL tmr_id: got %0d want 7", bus.irq_id_o); end
    n_vec++; if (bus.irq_pending_o !== 1'b1) begin n_err++; $display("FAIL tmr_pending: got %b want 1", bus.irq_pending_o); end
    n_vec++; if (bus.irq_enabled_o !== 1'b1) begin n_err++; $display("FAIL tmr_enabled: got %b want 1", bus.irq_enabled_o); end
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL tmr_ack_req: got %b want 0", bus.irq_req_o); end
    n_vec++; if (bus.irq_id_o !== 5'd7) begin n_err++; $display("FAIL tmr_hold_id: got %0d want 7", bus.irq_id_o); end
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL tmr_idle_req: got %b want 0", bus.irq_req_o); end
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL tmr_rereq: got %b want 1", bus.irq_req_o); end
    bus.irq_timer_i = 1'b0;
    tick(); tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL tmr_drop_req: got %b want 0", bus.irq_req_o); end
    $display("timer: request, ack, hold and re-request checked");
  endtask

  task automatic test_priority();
    logic [4:0] want_first;
    logic [31:0] want_mip;
`ifdef IRQ_FAST_EN
    want_first = 5'd18; want_mip = 32'h0004_0888;
`else
    want_first = 5'd11; want_mip = 32'h0000_0888;
`endif
    bus.csr_mie_i = 32'h0004_0888; bus.csr_mstatus_mie_i = 1'b1;
    bus.irq_software_i = 1'b1; bus.irq_external_i = 1'b1; bus.irq_timer_i = 1'b1;
    bus.irq_fast_i = 15'h0004;
    tick(); tick();
    n_vec++; if (bus.mip_o !== want_mip) begin n_err++; $display("FAIL prio_mip: got %h want %h", bus.mip_o, want_mip); end
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL prio_req: got %b want 1", bus.irq_req_o); end
    n_vec++; if (bus.irq_id_o !== want_first) begin n_err++; $display("FAIL prio_fast_id: got %0d want %0d", bus.irq_id_o, want_first); end
    bus.irq_fast_i = '0;
    tick(); tick();
    n_vec++; if (bus.irq_id_o !== 5'd11) begin n_err++; $display("FAIL prio_ext_id: got %0d want 11", bus.irq_id_o); end
    bus.irq_external_i = 1'b0;
    tick(); tick();
    n_vec++; if (bus.irq_id_o !== 5'd3) begin n_err++; $display("FAIL prio_sw_id: got %0d want 3", bus.irq_id_o); end
    bus.irq_software_i = 1'b0;
    tick(); tick();
    n_vec++; if (bus.irq_id_o !== 5'd7) begin n_err++; $display("FAIL prio_tmr_id: got %0d want 7", bus.irq_id_o); end
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL prio_tmr_req: got %b want 1", bus.irq_req_o); end
    bus.irq_timer_i = 1'b0;
    tick(); tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL prio_drop_req: got %b want 0", bus.irq_req_o); end
    n_vec++; if (bus.irq_pending_o !== 1'b0) begin n_err++; $display("FAIL prio_drop_pending: got %b want 0", bus.irq_pending_o); end
    $display("priority: fast > external > software > timer checked");
  endtask

  task automatic test_nmi();
    bus.csr_mie_i = '0; bus.csr_mstatus_mie_i = 1'b0;
    tick();
    bus.irq_nm_i = 1'b1;
    tick();
    n_vec++; if (bus.irq_nm_o !== 1'b0) begin n_err++; $display("FAIL nmi_early: got %b want 0", bus.irq_nm_o); end
    tick();
    n_vec++; if (bus.irq_nm_o !== 1'b1) begin n_err++; $display("FAIL nmi_nm: got %b want 1", bus.irq_nm_o); end
    n_vec++; if (bus.irq_id_o !== 5'd0) begin n_err++; $display("FAIL nmi_id: got %0d want 0", bus.irq_id_o); end
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL nmi_req: got %b want 1", bus.irq_req_o); end
    n_vec++; if (bus.irq_enabled_o !== 1'b0) begin n_err++; $display("FAIL nmi_enabled: got %b want 0", bus.irq_enabled_o); end
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL nmi_ack_req: got %b want 0", bus.irq_req_o); end
    n_vec++; if (bus.irq_nm_o !== 1'b1) begin n_err++; $display("FAIL nmi_hold_nm: got %b want 1", bus.irq_nm_o); end
    tick();
    n_vec++; if (bus.irq_nm_o !== 1'b0) begin n_err++; $display("FAIL nmi_cleared: got %b want 0", bus.irq_nm_o); end
    tick(); tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL nmi_no_rereq: got %b want 0", bus.irq_req_o); end
    // New edge coinciding with the clearing ack keeps the latch set.
    bus.irq_nm_i = 1'b0;
    tick();
    bus.irq_nm_i = 1'b1;
    tick();
    bus.irq_nm_i = 1'b0;
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL nmi2_req: got %b want 1", bus.irq_req_o); end
    bus.irq_ack_i = 1'b1; bus.irq_nm_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL nmi2_ack_req: got %b want 0", bus.irq_req_o); end
    tick();
    n_vec++; if (bus.irq_nm_o !== 1'b1) begin n_err++; $display("FAIL nmi2_kept: got %b want 1", bus.irq_nm_o); end
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL nmi2_rereq: got %b want 1", bus.irq_req_o); end
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;
    tick(); tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL nmi2_final_req: got %b want 0", bus.irq_req_o); end
    n_vec++; if (bus.irq_nm_o !== 1'b0) begin n_err++; $display("FAIL nmi2_final_nm: got %b want 0", bus.irq_nm_o); end
    bus.irq_nm_i = 1'b0;
    tick();
    $display("nmi: latch, ack clear and same-cycle edge checked");
  endtask

  task automatic test_debug();
    bus.csr_mie_i = 32'h0000_0800; bus.csr_mstatus_mie_i = 1'b1;
    bus.debug_mode_i = 1'b1; bus.irq_external_i = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL dbg_req: got %b want 0", bus.irq_req_o); end
    n_vec++; if (bus.irq_pending_o !== 1'b1) begin n_err++; $display("FAIL dbg_pending: got %b want 1", bus.irq_pending_o); end
    bus.debug_mode_i = 1'b0;
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL dbg_exit_req: got %b want 1", bus.irq_req_o); end
    n_vec++; if (bus.irq_id_o !== 5'd11) begin n_err++; $display("FAIL dbg_exit_id: got %0d want 11", bus.irq_id_o); end
    bus.nmi_mode_i = 1'b1;
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL nmimode_req: got %b want 0", bus.irq_req_o); end
    bus.nmi_mode_i = 1'b0;
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL nmimode_exit_req: got %b want 1", bus.irq_req_o); end
    bus.irq_external_i = 1'b0;
    tick(); tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL dbg_drop_req: got %b want 0", bus.irq_req_o); end
    $display("debug/nmi mode gating checked");
  endtask

  task automatic test_reset_mid();
    bus.csr_mie_i = 32'h0000_0080; bus.csr_mstatus_mie_i = 1'b1; bus.irq_timer_i = 1'b1;
    tick(); tick();
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL rmid_req: got %b want 1", bus.irq_req_o); end
    rst = 1'b1;
    tick();
    n_vec++; if (bus.mip_o !== 32'h0) begin n_err++; $display("FAIL rmid_mip: got %h want 0", bus.mip_o); end
    n_vec++; if (bus.irq_pending_o !== 1'b0) begin n_err++; $display("FAIL rmid_pending: got %b want 0", bus.irq_pending_o); end
    n_vec++; if (bus.irq_enabled_o !== 1'b0) begin n_err++; $display("FAIL rmid_enabled: got %b want 0", bus.irq_enabled_o); end
    n_vec++; if (bus.irq_id_o !== 5'd0) begin n_err++; $display("FAIL rmid_id: got %0d want 0", bus.irq_id_o); end
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL rmid_req0: got %b want 0", bus.irq_req_o); end
    rst = 1'b0;
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL rmid_early: got %b want 0", bus.irq_req_o); end
    tick();
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL rmid_rereq: got %b want 1", bus.irq_req_o); end
    n_vec++; if (bus.irq_id_o !== 5'd7) begin n_err++; $display("FAIL rmid_id7: got %0d want 7", bus.irq_id_o); end
    bus.irq_timer_i = 1'b0;
    tick(); tick();
    $display("reset mid-handshake checked");
  endtask

  task automatic test_fast_cfg();
    bus.csr_mie_i = 32'h7FFF_0000; bus.csr_mstatus_mie_i = 1'b1; bus.irq_fast_i = 15'h7FFF;
    tick(); tick();
    mip_v = bus.mip_o;
`ifdef IRQ_FAST_EN
    n_vec++; if (mip_v[30:16] !== 15'h7FFF) begin n_err++; $display("FAIL fast_mip: got %h want 7fff", mip_v[30:16]); end
    n_vec++; if (bus.irq_req_o !== 1'b1) begin n_err++; $display("FAIL fast_req: got %b want 1", bus.irq_req_o); end
    n_vec++; if (bus.irq_id_o !== 5'd30) begin n_err++; $display("FAIL fast_id: got %0d want 30", bus.irq_id_o); end
`else
    n_vec++; if (mip_v[30:16] !== 15'h0) begin n_err++; $display("FAIL nofast_mip: got %h want 0", mip_v[30:16]); end
    n_vec++; if (bus.irq_req_o !== 1'b0) begin n_err++; $display("FAIL nofast_req: got %b want 0", bus.irq_req_o); end
    n_vec++; if (bus.irq_pending_o !== 1'b0) begin n_err++; $display("FAIL nofast_pending: got %b want 0", bus.irq_pending_o); end
`endif
    bus.irq_fast_i = '0;
    tick(); tick();
    $display("fast-line configuration checked");
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    bus.irq_software_i = 1'b0; bus.irq_timer_i = 1'b0; bus.irq_external_i = 1'b0;
    bus.irq_fast_i = '0; bus.irq_nm_i = 1'b0; bus.csr_mie_i = '0;
    bus.csr_mstatus_mie_i = 1'b0; bus.debug_mode_i = 1'b0; bus.nmi_mode_i = 1'b0;
    bus.irq_ack_i = 1'b0;
    test_reset();
    test_timer();
    test_priority();
    test_nmi();
    test_debug();
    test_reset_mid();
    test_fast_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
